alu_op_sequencer: RTL

Control-side initiator for the datapath ALU: accepts an encoded operation request, drives exactly one of the ALU's one-hot operation strobes for the cycle(s) the ALU needs to latch it, then captures the ALU's registered 64-bit result into the ZHi/ZLo result registers. It sits between the instruction control unit and the ALU; the control unit sees a simple start/busy/done handshake and never touches the strobe lines directly.

---
 rtl/alu_op_sequencer.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer: control-side initiator for the datapath ALU.
// Takes an encoded operation request and pulses the matching one-hot ALU
// strobe. It then captures the ALU's registered 64-bit result into zhi/zlo.
// Optional divide support is compiled in with `define ALU_SEQ_DIV_EN.
//
// Handshake: the control unit raises start with a legal opcode while busy=0.
// The request is accepted at that clock edge and busy rises in the next cycle.
// busy stays high until the cycle after done. A start seen while busy=1 is
// dropped, not queued. An illegal opcode is answered with a one-cycle err
// pulse and no strobe.
module alu_op_sequencer #(
  parameter int DIV_LAT = 40
) (
  input  logic        clk,
  input  logic        clr_n,
  input  logic        start,
  input  logic [3:0]  opcode,
  output logic [12:0] op_oh,
  input  logic [63:0] alu_c,
  input  logic        div_ready,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [31:0] zhi,
  output logic [31:0] zlo,
  output logic [2:0]  dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_ISSUE   = 3'd1,
`ifdef ALU_SEQ_DIV_EN
    S_DIVWAIT = 3'd2,
`endif
    S_CAPTURE = 3'd3,
    S_DONE    = 3'd4
  } state_t;

  localparam logic [3:0] OP_DIV    = 4'd5;
  localparam logic [3:0] OP_LAST   = 4'd12;

  state_t      state_q;
  logic [12:0] op_oh_q;
  logic        busy_q;
  logic        done_q;
  logic        err_q;
  logic [31:0] zhi_q;
  logic [31:0] zlo_q;
  logic        legal_d;

`ifdef ALU_SEQ_DIV_EN
  localparam logic [5:0] WAIT_LIMIT = 6'(DIV_LAT - 1);
  logic        is_div_q;
  logic        timeout_q;
  logic [5:0]  wait_cnt_q;
  logic        unused_ok;
  assign unused_ok = 1'b0;
`else
  // Divide path not built: div_ready and DIV_LAT are intentionally unused.
  logic        unused_ok;
  assign unused_ok = div_ready ^ (DIV_LAT == 0);
`endif

  // Decode which opcodes this build accepts.
  always_comb begin
    legal_d = (opcode <= OP_LAST);
`ifndef ALU_SEQ_DIV_EN
    if (opcode == OP_DIV) legal_d = 1'b0;
`endif
  end

  // Sequencer FSM with all outputs registered.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state_q    <= S_IDLE;
      op_oh_q    <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      zhi_q      <= '0;
      zlo_q      <= '0;
`ifdef ALU_SEQ_DIV_EN
      is_div_q   <= 1'b0;
      timeout_q  <= 1'b0;
      wait_cnt_q <= '0;
`endif
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start) begin
            if (legal_d) begin
              state_q <= S_ISSUE;
              op_oh_q <= 13'b1 << opcode;
              busy_q  <= 1'b1;
`ifdef ALU_SEQ_DIV_EN
              is_div_q  <= (opcode == OP_DIV);
              timeout_q <= 1'b0;
`endif
            end else begin
              err_q <= 1'b1;
            end
          end
        end
        S_ISSUE: begin
`ifdef ALU_SEQ_DIV_EN
          if (is_div_q) begin
            // Strobe stays high while the divider works.
            state_q    <= S_DIVWAIT;
            wait_cnt_q <= '0;
          end else begin
            state_q <= S_CAPTURE;
            op_oh_q <= '0;
          end
`else
          state_q <= S_CAPTURE;
          op_oh_q <= '0;
`endif
        end
`ifdef ALU_SEQ_DIV_EN
        S_DIVWAIT: begin
          if (div_ready) begin
            // Ready at the limit still counts as success.
            state_q <= S_CAPTURE;
            op_oh_q <= '0;
          end else if (wait_cnt_q == WAIT_LIMIT) begin
            state_q   <= S_CAPTURE;
            op_oh_q   <= '0;
            timeout_q <= 1'b1;
          end else begin
            wait_cnt_q <= wait_cnt_q + 6'd1;
          end
        end
`endif
        S_CAPTURE: begin
          zhi_q   <= alu_c[63:32];
          zlo_q   <= alu_c[31:0];
          done_q  <= 1'b1;
`ifdef ALU_SEQ_DIV_EN
          err_q   <= timeout_q;
`endif
          state_q <= S_DONE;
        end
        S_DONE: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= S_IDLE;
          op_oh_q <= '0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign op_oh     = op_oh_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign err       = err_q;
  assign zhi       = zhi_q;
  assign zlo       = zlo_q;
  assign dbg_state = state_q;

endmodule
